// File: rtl/lc3_mmio_ctrl_if.sv
// Bus bundle between the LC-3 core, data memory and the MMIO stage (core bus, keyboard in, display out).
// Combinational signal bundle only; no latency of its own.
// Keyboard is valid/ready upstream, display is valid/ready downstream; kb_irq/disp_irq exist only with LC3_MMIO_IRQ_EN.
interface lc3_mmio_ctrl_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] mar;
  logic [15:0]       mdr;
  logic              memwe;
  logic [15:0]       mem_rdata;
  logic [15:0]       memOut;
  logic              mem_we_out;
  logic              kb_valid;
  logic [7:0]        kb_data;
  logic              kb_ready;
  logic              disp_valid;
  logic [7:0]        disp_data;
  logic              disp_ready;
  logic              run;
`ifdef LC3_MMIO_IRQ_EN
  logic              kb_irq;
  logic              disp_irq;
`endif

  // MMIO stage side
  modport slave (
    input  mar, mdr, memwe, mem_rdata, kb_valid, kb_data, disp_ready,
    output memOut, mem_we_out, kb_ready, disp_valid, disp_data, run
`ifdef LC3_MMIO_IRQ_EN
    , output kb_irq, disp_irq
`endif
  );

  // Core / memory / device side
  modport master (
    output mar, mdr, memwe, mem_rdata, kb_valid, kb_data, disp_ready,
    input  memOut, mem_we_out, kb_ready, disp_valid, disp_data, run
`ifdef LC3_MMIO_IRQ_EN
    , input kb_irq, disp_irq
`endif
  );
endinterface

// File: rtl/lc3_mmio_ctrl.sv
// LC-3 MMIO stage: decodes xFE00-xFFFF (KBSR/KBDR/DSR/DDR/MCR), muxes read data, blocks device writes to memory.
// Read mux and mem write gate are combinational; register writes take effect on the next edge; kb char visible 2 edges after push.
// kb_ready drops when the keyboard FIFO is full; display holds disp_valid until disp_ready. Optional IRQs: LC3_MMIO_IRQ_EN.

// Small generic FIFO: registered count, no internal overflow/underflow guarding (caller gates push/pop).
module lc3_mmio_kb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_dat,
  input  logic         i_pop,
  output logic [W-1:0] o_dat,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  // Storage write; contents need no reset because the count gates visibility
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_dat;
  end

  // Pointers wrap naturally (power-of-2 depth); simultaneous push/pop keeps count
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_dat   = r_mem[r_rd_ptr];
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
endmodule

module lc3_mmio_ctrl #(
  parameter int KB_FIFO_DEPTH = 4,
  parameter int ADDR_W        = 16
) (
  input  logic               clk,
  input  logic               reset,
  lc3_mmio_ctrl_if.slave     bus
);
  localparam logic [ADDR_W-1:0] A_KBSR = 16'hFE00;
  localparam logic [ADDR_W-1:0] A_KBDR = 16'hFE02;
  localparam logic [ADDR_W-1:0] A_DSR  = 16'hFE04;
  localparam logic [ADDR_W-1:0] A_DDR  = 16'hFE06;
  localparam logic [ADDR_W-1:0] A_MCR  = 16'hFFFE;

  typedef enum logic {DISP_IDLE, DISP_SEND} disp_state_t;

  // Address decode
  logic w_mmio_hit, w_sel_kbsr, w_sel_kbdr, w_sel_dsr, w_sel_ddr, w_sel_mcr;
  assign w_mmio_hit = (bus.mar[ADDR_W-1 -: 7] == 7'h7F);
  assign w_sel_kbsr = (bus.mar == A_KBSR);
  assign w_sel_kbdr = (bus.mar == A_KBDR);
  assign w_sel_dsr  = (bus.mar == A_DSR);
  assign w_sel_ddr  = (bus.mar == A_DDR);
  assign w_sel_mcr  = (bus.mar == A_MCR);

  // Device-page writes never reach memory
  assign bus.mem_we_out = bus.memwe & ~w_mmio_hit;

  // One strobe per device write, however long memwe is held
  logic w_wr_lvl, r_wr_lvl_q, w_wr_stb;
  assign w_wr_lvl = bus.memwe & w_mmio_hit;
  assign w_wr_stb = w_wr_lvl & ~r_wr_lvl_q;

  // The KBDR access ends when the core moves mar away; that is when the char is consumed
  logic r_kb_sel_q, w_kb_consume;
  assign w_kb_consume = r_kb_sel_q & ~w_sel_kbdr;

  // Edge-detect registers for write strobe and KBDR access end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_lvl_q <= 1'b0;
      r_kb_sel_q <= 1'b0;
    end else begin
      r_wr_lvl_q <= w_wr_lvl;
      r_kb_sel_q <= w_sel_kbdr;
    end
  end

  // Keyboard FIFO feeding the KBDR holding register
  logic       w_fifo_full, w_fifo_empty, w_kb_push, w_kb_load;
  logic [7:0] w_fifo_dat;
  logic       r_kb_rdy, r_ie;
  logic [7:0] r_kbdr;

  assign bus.kb_ready = ~w_fifo_full;
  assign w_kb_push    = bus.kb_valid & ~w_fifo_full;
  // Consume beats load; a deferred load happens the cycle after
  assign w_kb_load    = ~r_kb_rdy & ~w_fifo_empty & ~w_kb_consume;

  lc3_mmio_kb_fifo #(.DEPTH(KB_FIFO_DEPTH), .W(8)) u_kb_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_kb_push),
    .i_dat   (bus.kb_data),
    .i_pop   (w_kb_load),
    .o_dat   (w_fifo_dat),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // KBDR load/consume and KBSR interrupt-enable storage
  always_ff @(posedge clk) begin
    if (reset) begin
      r_kb_rdy <= 1'b0;
      r_kbdr   <= 8'h00;
      r_ie     <= 1'b0;
    end else begin
      if (w_kb_consume) begin
        r_kb_rdy <= 1'b0;
      end else if (w_kb_load) begin
        r_kb_rdy <= 1'b1;
        r_kbdr   <= w_fifo_dat;
      end
      if (w_wr_stb && w_sel_kbsr) r_ie <= bus.mdr[14];
    end
  end

  // Display FSM
  disp_state_t r_disp_state, w_disp_state_nxt;
  logic        w_disp_load, w_ds_rdy, w_disp_valid;
  logic [7:0]  r_disp_data;

  // Display state register
  always_ff @(posedge clk) begin
    if (reset) r_disp_state <= DISP_IDLE;
    else       r_disp_state <= w_disp_state_nxt;
  end

  // Display next state and outputs; a DDR write while busy is dropped
  always_comb begin
    w_disp_state_nxt = r_disp_state;
    w_disp_load      = 1'b0;
    w_ds_rdy         = 1'b0;
    w_disp_valid     = 1'b0;
    case (r_disp_state)
      DISP_IDLE: begin
        w_ds_rdy = 1'b1;
        if (w_wr_stb && w_sel_ddr) begin
          w_disp_load      = 1'b1;
          w_disp_state_nxt = DISP_SEND;
        end
      end
      DISP_SEND: begin
        w_disp_valid = 1'b1;
        if (bus.disp_ready) w_disp_state_nxt = DISP_IDLE;
      end
      default: w_disp_state_nxt = DISP_IDLE;
    endcase
  end

  // Display char register, only loaded on an accepted DDR write
  always_ff @(posedge clk) begin
    if (reset)            r_disp_data <= 8'h00;
    else if (w_disp_load) r_disp_data <= bus.mdr[7:0];
  end

  assign bus.disp_valid = w_disp_valid;
  assign bus.disp_data  = r_disp_data;

  // Machine control: only reset or an MCR write changes run
  logic r_run;
  always_ff @(posedge clk) begin
    if (reset)                      r_run <= 1'b1;
    else if (w_wr_stb && w_sel_mcr) r_run <= bus.mdr[15];
  end
  assign bus.run = r_run;

  logic w_dsr_ie;
`ifdef LC3_MMIO_IRQ_EN
  logic r_dsr_ie, r_kb_irq, r_disp_irq;
  // Display interrupt enable plus registered interrupt outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dsr_ie   <= 1'b0;
      r_kb_irq   <= 1'b0;
      r_disp_irq <= 1'b0;
    end else begin
      if (w_wr_stb && w_sel_dsr) r_dsr_ie <= bus.mdr[14];
      r_kb_irq   <= r_ie & r_kb_rdy;
      r_disp_irq <= r_dsr_ie & w_ds_rdy;
    end
  end
  assign w_dsr_ie     = r_dsr_ie;
  assign bus.kb_irq   = r_kb_irq;
  assign bus.disp_irq = r_disp_irq;
`else
  assign w_dsr_ie = 1'b0;
`endif

  // Read data mux back to the core; unmapped device addresses read 0
  logic [15:0] w_rdata;
  always_comb begin
    w_rdata = 16'h0000;
    if (!w_mmio_hit)     w_rdata = bus.mem_rdata;
    else if (w_sel_kbsr) w_rdata = {r_kb_rdy, r_ie, 14'b0};
    else if (w_sel_kbdr) w_rdata = {8'h00, r_kbdr};
    else if (w_sel_dsr)  w_rdata = {w_ds_rdy, w_dsr_ie, 14'b0};
    else if (w_sel_mcr)  w_rdata = {r_run, 15'b0};
  end
  assign bus.memOut = w_rdata;

  // mdr bits that no register stores
  logic w_unused_mdr;
  assign w_unused_mdr = ^bus.mdr[13:8];
endmodule

// File: tb/tb_lc3_mmio_ctrl.sv
module tb_lc3_mmio_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lc3_mmio_ctrl_if #(.ADDR_W(16)) bus();

  lc3_mmio_ctrl #(.KB_FIFO_DEPTH(4), .ADDR_W(16)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] kb_q[$];
  logic [7:0] disp_q[$];

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Offer one keyboard char for one cycle; expected only if kb_ready allows the push
  task automatic push_kb(input logic [7:0] ch);
    bus.kb_valid = 1'b1;
    bus.kb_data  = ch;
    #1;
    if (bus.kb_ready === 1'b1) kb_q.push_back(ch);
    cyc();
    bus.kb_valid = 1'b0;
  endtask

  // Wait for KBSR ready, read KBDR for 'hold' cycles against the scoreboard, then end the access
  task automatic read_kbdr(input int hold);
    logic [7:0] exp;
    int w;
    bus.mar = 16'hFE00;
    #1;
    w = 0;
    while (bus.memOut[15] !== 1'b1 && w < 4) begin cyc(); #1; w++; end
    n_cmp++;
    if (bus.memOut[15] !== 1'b1) begin
      n_err++; $display("FAIL kbsr_ready_wait: KBSR=%h, bit15 required 1", bus.memOut);
    end
    exp = 8'h00;
    if (kb_q.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL kb_scoreboard: DUT offers KBDR=%h but no char expected", bus.memOut);
    end else begin
      exp = kb_q.pop_front();
    end
    bus.mar = 16'hFE02;
    for (int i = 0; i < hold; i++) begin
      #1;
      n_cmp++;
      if (bus.memOut !== {8'h00, exp}) begin
        n_err++; $display("FAIL kbdr_read[%0d]: got %h want %h", i, bus.memOut, {8'h00, exp});
      end
      cyc();
    end
    bus.mar = 16'h3000;
    cyc();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    #1;
    n_cmp++; if (bus.run !== 1'b1) begin n_err++; $display("FAIL reset_run: got %b want 1", bus.run); end
    n_cmp++; if (bus.kb_ready !== 1'b1) begin n_err++; $display("FAIL reset_kb_ready: got %b want 1", bus.kb_ready); end
    n_cmp++; if (bus.disp_valid !== 1'b0) begin n_err++; $display("FAIL reset_disp_valid: got %b want 0", bus.disp_valid); end
    n_cmp++; if (bus.disp_data !== 8'h00) begin n_err++; $display("FAIL reset_disp_data: got %h want 00", bus.disp_data); end
    bus.mar = 16'hFE00; #1;
    n_cmp++; if (bus.memOut !== 16'h0000) begin n_err++; $display("FAIL reset_kbsr: got %h want 0000", bus.memOut); end
    bus.mar = 16'hFE04; #1;
    n_cmp++; if (bus.memOut !== 16'h8000) begin n_err++; $display("FAIL reset_dsr: got %h want 8000", bus.memOut); end
    bus.mar = 16'hFFFE; #1;
    n_cmp++; if (bus.memOut !== 16'h8000) begin n_err++; $display("FAIL reset_mcr: got %h want 8000", bus.memOut); end
    bus.mar = 16'hFE02; #1;
    n_cmp++; if (bus.memOut !== 16'h0000) begin n_err++; $display("FAIL reset_kbdr: got %h want 0000", bus.memOut); end
    bus.mar = 16'h3000;
    cyc();
  endtask

  task automatic test_passthrough();
    bus.mar = 16'h3000; bus.mdr = 16'h1234; bus.memwe = 1'b1; bus.mem_rdata = 16'hBEEF;
    #1;
    n_cmp++; if (bus.mem_we_out !== 1'b1) begin n_err++; $display("FAIL mem_we_pass: got %b want 1", bus.mem_we_out); end
    n_cmp++; if (bus.memOut !== 16'hBEEF) begin n_err++; $display("FAIL mem_rdata_pass: got %h want BEEF", bus.memOut); end
    bus.mar = 16'hFE04; #1;
    n_cmp++; if (bus.mem_we_out !== 1'b0) begin n_err++; $display("FAIL mem_we_block: got %b want 0", bus.mem_we_out); end
    bus.memwe = 1'b0;
    bus.mar = 16'hFE10; #1;
    n_cmp++; if (bus.memOut !== 16'h0000) begin n_err++; $display("FAIL unmapped_read: got %h want 0000", bus.memOut); end
    bus.mar = 16'hFDFE; #1;
    n_cmp++; if (bus.memOut !== 16'hBEEF) begin n_err++; $display("FAIL below_page_read: got %h want BEEF", bus.memOut); end
    bus.mar = 16'h3000;
    cyc();
  endtask

  task automatic test_keyboard();
    int w;
    push_kb(8'h41);
    bus.mar = 16'hFE00;
    #1;
    w = 0;
    while (bus.memOut !== 16'h8000 && w < 2) begin cyc(); #1; w++; end
    n_cmp++; if (bus.memOut !== 16'h8000) begin n_err++; $display("FAIL kbsr_after_push: got %h want 8000", bus.memOut); end
    read_kbdr(3);
    bus.mar = 16'hFE00; #1;
    n_cmp++; if (bus.memOut !== 16'h0000) begin n_err++; $display("FAIL kbsr_consumed: got %h want 0000", bus.memOut); end
    push_kb(8'h42);
    push_kb(8'h43);
    read_kbdr(1);
    bus.mar = 16'hFE00;
    #1;
    w = 0;
    while (bus.memOut !== 16'h8000 && w < 2) begin cyc(); #1; w++; end
    n_cmp++; if (bus.memOut !== 16'h8000) begin n_err++; $display("FAIL kbsr_second_char: got %h want 8000", bus.memOut); end
    read_kbdr(2);
    bus.mar = 16'hFE00; cyc(); cyc(); #1;
    n_cmp++; if (bus.memOut !== 16'h0000) begin n_err++; $display("FAIL kbsr_drained: got %h want 0000", bus.memOut); end
    bus.mar = 16'h3000;
  endtask

  task automatic test_fifo_full();
    int w;
    for (int i = 0; i < 5; i++) push_kb(8'(8'h30 + i));
    #1;
    n_cmp++; if (bus.kb_ready !== 1'b0) begin n_err++; $display("FAIL full_kb_ready: got %b want 0", bus.kb_ready); end
    bus.kb_valid = 1'b1; bus.kb_data = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (bus.kb_ready !== 1'b0) begin n_err++; $display("FAIL full_hold_z[%0d]: kb_ready=%b want 0", i, bus.kb_ready); end
      cyc();
    end
    bus.kb_valid = 1'b0;
    read_kbdr(1);
    #1;
    w = 0;
    while (bus.kb_ready !== 1'b1 && w < 2) begin cyc(); #1; w++; end
    n_cmp++; if (bus.kb_ready !== 1'b1) begin n_err++; $display("FAIL ready_after_read: got %b want 1", bus.kb_ready); end
    for (int i = 0; i < 4; i++) read_kbdr(1);
    bus.mar = 16'hFE00; cyc(); cyc(); #1;
    n_cmp++; if (bus.memOut !== 16'h0000) begin n_err++; $display("FAIL fifo_no_z: KBSR=%h want 0000", bus.memOut); end
    bus.mar = 16'h3000;
  endtask

  task automatic test_display();
    logic [7:0] exp;
    bus.disp_ready = 1'b0;
    bus.mar = 16'hFE06; bus.mdr = 16'h0048; bus.memwe = 1'b1;
    disp_q.push_back(8'h48);
    for (int i = 0; i < 4; i++) cyc();
    bus.memwe = 1'b0;
    #1;
    n_cmp++; if (bus.disp_valid !== 1'b1) begin n_err++; $display("FAIL ddr_send: disp_valid=%b want 1", bus.disp_valid); end
    bus.mar = 16'hFE04; #1;
    n_cmp++; if (bus.memOut !== 16'h0000) begin n_err++; $display("FAIL dsr_busy: got %h want 0000", bus.memOut); end
    bus.mar = 16'hFE06; bus.mdr = 16'h0049; bus.memwe = 1'b1;
    cyc();
    bus.memwe = 1'b0;
    cyc();
    bus.disp_ready = 1'b1;
    #1;
    if (bus.disp_valid === 1'b1 && disp_q.size() > 0) begin
      exp = disp_q.pop_front();
      n_cmp++; if (bus.disp_data !== exp) begin n_err++; $display("FAIL disp_char: got %h want %h", bus.disp_data, exp); end
    end else begin
      n_cmp++; n_err++; $display("FAIL disp_handshake: disp_valid=%b, expected chars=%0d", bus.disp_valid, disp_q.size());
    end
    cyc();
    bus.disp_ready = 1'b0;
    #1;
    n_cmp++; if (bus.disp_valid !== 1'b0) begin n_err++; $display("FAIL disp_done: disp_valid=%b want 0", bus.disp_valid); end
    bus.mar = 16'hFE04; #1;
    n_cmp++; if (bus.memOut !== 16'h8000) begin n_err++; $display("FAIL dsr_idle: got %h want 8000", bus.memOut); end
    cyc();
    n_cmp++; if (bus.disp_valid !== 1'b0) begin n_err++; $display("FAIL dropped_write: disp_valid=%b want 0", bus.disp_valid); end
    bus.mar = 16'h3000;
  endtask

  // Two DDR writes with the sink always ready: held memwe must give one char per write
  task automatic test_back_to_back();
    logic [7:0] exp;
    int hs;
    hs = 0;
    bus.disp_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      bus.mar = 16'hFE06; bus.mdr = 16'(16'h0055 + k); bus.memwe = 1'b1;
      disp_q.push_back(8'(8'h55 + k));
      for (int i = 0; i < 5; i++) begin
        cyc();
        #1;
        if (bus.disp_valid === 1'b1) begin
          hs++;
          exp = (disp_q.size() > 0) ? disp_q.pop_front() : 8'hxx;
          n_cmp++; if (bus.disp_data !== exp) begin n_err++; $display("FAIL b2b_char: got %h want %h", bus.disp_data, exp); end
        end
      end
      bus.memwe = 1'b0;
      cyc();
    end
    bus.disp_ready = 1'b0;
    n_cmp++; if (hs !== 2) begin n_err++; $display("FAIL b2b_count: got %0d chars want 2", hs); end
    bus.mar = 16'h3000;
  endtask

  task automatic test_halt_and_reset();
    bus.mar = 16'hFFFE; bus.mdr = 16'h0000; bus.memwe = 1'b1;
    #1;
    n_cmp++; if (bus.run !== 1'b1) begin n_err++; $display("FAIL run_before_edge: got %b want 1", bus.run); end
    cyc();
    bus.memwe = 1'b0;
    #1;
    n_cmp++; if (bus.run !== 1'b0) begin n_err++; $display("FAIL halt_run: got %b want 0", bus.run); end
    n_cmp++; if (bus.memOut !== 16'h0000) begin n_err++; $display("FAIL halt_mcr: got %h want 0000", bus.memOut); end
    bus.mar = 16'hFE06; bus.mdr = 16'h0058; bus.memwe = 1'b1; bus.disp_ready = 1'b0;
    cyc();
    bus.memwe = 1'b0; bus.mar = 16'h3000;
    push_kb(8'h51);
    reset = 1'b1;
    cyc();
    #1;
    n_cmp++; if (bus.disp_valid !== 1'b0) begin n_err++; $display("FAIL reset_abandon: disp_valid=%b want 0", bus.disp_valid); end
    cyc();
    reset = 1'b0;
    kb_q.delete();
    disp_q.delete();
    #1;
    n_cmp++; if (bus.run !== 1'b1) begin n_err++; $display("FAIL reset_run_restore: got %b want 1", bus.run); end
    n_cmp++; if (bus.disp_data !== 8'h00) begin n_err++; $display("FAIL reset_disp_clear: got %h want 00", bus.disp_data); end
    bus.mar = 16'hFE04; #1;
    n_cmp++; if (bus.memOut !== 16'h8000) begin n_err++; $display("FAIL reset_dsr_ready: got %h want 8000", bus.memOut); end
    bus.mar = 16'hFE00; cyc(); cyc(); #1;
    n_cmp++; if (bus.memOut !== 16'h0000) begin n_err++; $display("FAIL reset_flush: KBSR=%h want 0000", bus.memOut); end
    bus.mar = 16'h3000;
    cyc();
  endtask

`ifdef LC3_MMIO_IRQ_EN
  task automatic test_irq();
    logic [7:0] exp;
    int w;
    bus.mar = 16'hFE00; bus.mdr = 16'h4000; bus.memwe = 1'b1;
    cyc();
    bus.memwe = 1'b0;
    #1;
    n_cmp++; if (bus.memOut !== 16'h4000) begin n_err++; $display("FAIL kbsr_ie: got %h want 4000", bus.memOut); end
    n_cmp++; if (bus.kb_irq !== 1'b0) begin n_err++; $display("FAIL kb_irq_idle: got %b want 0", bus.kb_irq); end
    push_kb(8'h61);
    #1;
    w = 0;
    while (bus.memOut[15] !== 1'b1 && w < 3) begin cyc(); #1; w++; end
    n_cmp++; if (bus.kb_irq !== 1'b0) begin n_err++; $display("FAIL kb_irq_lag: got %b want 0", bus.kb_irq); end
    cyc(); #1;
    n_cmp++; if (bus.kb_irq !== 1'b1) begin n_err++; $display("FAIL kb_irq_set: got %b want 1", bus.kb_irq); end
    exp = (kb_q.size() > 0) ? kb_q.pop_front() : 8'hxx;
    bus.mar = 16'hFE02; #1;
    n_cmp++; if (bus.memOut !== {8'h00, exp}) begin n_err++; $display("FAIL irq_kbdr: got %h want %h", bus.memOut, {8'h00, exp}); end
    cyc();
    bus.mar = 16'h3000;
    cyc(); cyc(); #1;
    n_cmp++; if (bus.kb_irq !== 1'b0) begin n_err++; $display("FAIL kb_irq_clear: got %b want 0", bus.kb_irq); end
    bus.mar = 16'hFE04; bus.mdr = 16'h4000; bus.memwe = 1'b1;
    cyc();
    bus.memwe = 1'b0;
    #1;
    n_cmp++; if (bus.memOut !== 16'hC000) begin n_err++; $display("FAIL dsr_ie_read: got %h want C000", bus.memOut); end
    cyc(); #1;
    n_cmp++; if (bus.disp_irq !== 1'b1) begin n_err++; $display("FAIL disp_irq_set: got %b want 1", bus.disp_irq); end
    bus.mdr = 16'h0000; bus.memwe = 1'b1;
    cyc();
    bus.memwe = 1'b0; bus.mar = 16'hFE00; bus.memwe = 1'b1;
    cyc();
    bus.memwe = 1'b0; bus.mar = 16'h3000;
    cyc();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    bus.mar        = 16'h3000;
    bus.mdr        = 16'h0000;
    bus.memwe      = 1'b0;
    bus.mem_rdata  = 16'hABCD;
    bus.kb_valid   = 1'b0;
    bus.kb_data    = 8'h00;
    bus.disp_ready = 1'b0;
    test_reset();
    test_passthrough();
    test_keyboard();
    test_fifo_full();
    test_display();
    test_back_to_back();
    test_halt_and_reset();
`ifdef LC3_MMIO_IRQ_EN
    test_irq();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/lc3_mmio_ctrl.md
Name: lc3_mmio_ctrl

Overview:
- Memory-mapped I/O stage between the LC-3 core's memory bus (mar, mdr, memwe, memOut) and the data memory.
- Decodes the LC-3 device page xFE00–xFFFF.
- Provides keyboard (KBSR/KBDR), display (DSR/DDR) and machine control (MCR) registers.
- Muxes device or memory read data back to the core and blocks device-page writes from reaching memory.

Parameters:
KB_FIFO_DEPTH, 4, keyboard input FIFO entries; power of 2, minimum 2
ADDR_W, 16, bus address width; LC-3 fixed

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
mar  input  16  core memory address
mdr  input  16  core write data
memwe  input  1  core write enable (level, may span several cycles)
mem_rdata  input  16  read data from data memory
memOut  output  16  read data to core
mem_we_out  output  1  write enable to data memory
kb_valid  input  1  keyboard char valid (upstream handshake)
kb_data  input  8  keyboard ASCII char
kb_ready  output  1  FIFO can accept a char
disp_valid  output  1  display char valid (downstream handshake)
disp_data  output  8  display ASCII char
disp_ready  input  1  display sink accepts the char
run  output  1  MCR[15]; core clock-enable

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high. All state changes happen on the rising edge of clk.
- Decode: mmio_hit = (mar[15:9] == 7'h7F).
  - KBSR = xFE00, KBDR = xFE02, DSR = xFE04, DDR = xFE06, MCR = xFFFE.
  - Any other device-page address reads 0; writes to it are ignored.
- mem_we_out = memwe & ~mmio_hit (combinational).
- memOut (combinational):
  - mem_rdata when ~mmio_hit.
  - KBSR = {kb_rdy, ie, 14'b0}
  - KBDR = {8'b0, kbdr}
  - DSR = {ds_rdy, 15'b0}
  - MCR = {run, 15'b0}
- Write strobe: wr_stb = rising edge of (memwe & mmio_hit) for the current mar. It is one pulse per write, and held memwe does not repeat the write. The previous-cycle qualifier is registered.
- Keyboard path:
  - Push when kb_valid & kb_ready. kb_ready = ~fifo_full (registered count).
  - Load: when kb_rdy == 0 and the FIFO is not empty, pop the head into kbdr and set kb_rdy = 1 on the next edge.
  - Consume: kb_rdy clears on the edge where the registered "mar == KBDR" goes 1→0, i.e. when the core's access ends. kbdr stays stable throughout the access.
  - Simultaneous push and pop keep the count unchanged. A push when full cannot occur (kb_ready = 0). Pointers wrap modulo KB_FIFO_DEPTH.
  - If a consume and a load are eligible in the same cycle, the consume wins. The load happens the following cycle.
  - wr_stb to KBSR: ie <= mdr[14]. Other bits are read-only.
- Display path:
  - FSM states: IDLE (ds_rdy = 1, disp_valid = 0) and SEND (ds_rdy = 0, disp_valid = 1).
  - IDLE→SEND on wr_stb to DDR: disp_data <= mdr[7:0].
  - SEND→IDLE on disp_ready & disp_valid.
  - A write to DDR in SEND is dropped and disp_data is unchanged.
  - Writes to DSR are ignored.
- MCR: wr_stb to MCR sets run <= mdr[15]. Only reset or an MCR write can change run.
- Reset values:
  - run = 1, ds_rdy = 1, disp_valid = 0, disp_data = 0.
  - kb_rdy = 0, kbdr = 0, ie = 0, FIFO empty (kb_ready = 1).
  - Edge-detect registers = 0.
  - Reset mid-transfer abandons a pending display char (disp_valid drops the next cycle) and flushes the FIFO.

Optional Feature:
- Macro: LC3_MMIO_IRQ_EN.
- When defined:
  - Adds output port kb_irq (1 bit), registered: kb_irq <= ie & kb_rdy. Reset value 0.
  - Adds output port disp_irq (1 bit): disp_irq <= dsr_ie & ds_rdy, with DSR[14] as a writable dsr_ie (reset value 0). DSR then reads {ds_rdy, dsr_ie, 14'b0}.
- When undefined:
  - Neither port exists.
  - DSR[14] reads 0; KBSR[14] remains read/write storage with no effect.

Test Plan:
- Memory pass-through: memwe = 1, mar = x3000, mdr = x1234 → mem_we_out = 1; memOut = mem_rdata. With mar = xFE04 and memwe = 1 → mem_we_out = 0.
- Keyboard read: push 'A' (x41) → within 2 cycles KBSR reads x8000. Hold mar = xFE02 for 3 cycles → memOut = x0041 throughout. Move mar to x3000 → KBSR reads x0000 the next cycle, or x8000 again if a second char is queued.
- FIFO full: push 5 chars with no reads (depth 4 plus holding register) → kb_ready = 0 after the 5th; kb_valid held with 'Z' is not accepted. Read KBDR once → kb_ready = 1 within 2 cycles.
- Display: write DDR = x0048 with memwe held 4 cycles, disp_ready = 0 → exactly one SEND, disp_data = x48, DSR = x0000. A second write x0049 while busy is dropped. disp_ready = 1 for 1 cycle → disp_valid = 0 and DSR = x8000.
- Halt: write MCR = x0000 → run = 0 the next cycle and MCR reads x0000. Assert reset → run = 1 and DSR = x8000.
- With LC3_MMIO_IRQ_EN: write KBSR = x4000, then push a char → kb_irq = 1 one cycle after kb_rdy rises, and kb_irq = 0 after the KBDR access ends.
